// File: rtl/avionics_pkg.sv
// -----------------------------------------------------------------------------
// avionics_pkg
// Shared definitions for the radio pulse capture path:
//   - channel FSM state encoding (ARM, WAIT_RISE, HIGH)
//   - default pulse timing constants in microseconds
//   - counter and radio value widths
//   - helpers that judge a measured pulse width and map it to a command value
// -----------------------------------------------------------------------------
package avionics_pkg;

    localparam int RADIO_VAL_W   = 10;
    localparam int WIDTH_CNT_W   = 12;
    localparam int TIMEOUT_CNT_W = 16;

    localparam int DEF_NUM_CH       = 8;
    localparam int DEF_MIN_US       = 1000;
    localparam int DEF_MAX_US       = 2000;
    localparam int DEF_ACCEPT_LO_US = 800;
    localparam int DEF_ACCEPT_HI_US = 2200;
    localparam int DEF_ABORT_US     = 2500;
    localparam int DEF_TIMEOUT_US   = 50000;

    typedef enum logic [1:0] {
        CH_ARM       = 2'd0,
        CH_WAIT_RISE = 2'd1,
        CH_HIGH      = 2'd2
    } ch_state_t;

    // True when the measured width lies inside the inclusive acceptance window.
    function automatic logic pulse_is_valid(
        input logic [WIDTH_CNT_W-1:0] width,
        input logic [WIDTH_CNT_W-1:0] lo,
        input logic [WIDTH_CNT_W-1:0] hi
    );
        return (width >= lo) && (width <= hi);
    endfunction

    // Clamp the width to [lo, hi] and offset it so that lo maps to zero.
    function automatic logic [RADIO_VAL_W-1:0] pulse_to_value(
        input logic [WIDTH_CNT_W-1:0] width,
        input logic [WIDTH_CNT_W-1:0] lo,
        input logic [WIDTH_CNT_W-1:0] hi
    );
        logic [WIDTH_CNT_W-1:0] clamped;
        if (width < lo) begin
            clamped = lo;
        end else if (width > hi) begin
            clamped = hi;
        end else begin
            clamped = width;
        end
        return RADIO_VAL_W'(clamped - lo);
    endfunction

endpackage

// File: rtl/radio_channel_capture.sv
// -----------------------------------------------------------------------------
// radio_channel_capture
// Measures one RC PWM channel and produces its 10-bit command value and a
// validity flag.
//   clk, rst   system clock, asynchronous active-high reset
//   tick_1us   one-clk strobe every microsecond
//   sig        raw receiver pin (asynchronous to clk)
//   value      last accepted command, 0..1000
//   ok         a valid pulse has been seen within the timeout window
// -----------------------------------------------------------------------------
module radio_channel_capture
    import avionics_pkg::*;
#(
    parameter int MIN_US       = DEF_MIN_US,
    parameter int MAX_US       = DEF_MAX_US,
    parameter int ACCEPT_LO_US = DEF_ACCEPT_LO_US,
    parameter int ACCEPT_HI_US = DEF_ACCEPT_HI_US,
    parameter int ABORT_US     = DEF_ABORT_US,
    parameter int TIMEOUT_US   = DEF_TIMEOUT_US
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_1us,
    input  logic                   sig,
    output logic [RADIO_VAL_W-1:0] value,
    output logic                   ok
);

    localparam logic [WIDTH_CNT_W-1:0]   MIN_W      = WIDTH_CNT_W'(MIN_US);
    localparam logic [WIDTH_CNT_W-1:0]   MAX_W      = WIDTH_CNT_W'(MAX_US);
    localparam logic [WIDTH_CNT_W-1:0]   ACC_LO_W   = WIDTH_CNT_W'(ACCEPT_LO_US);
    localparam logic [WIDTH_CNT_W-1:0]   ACC_HI_W   = WIDTH_CNT_W'(ACCEPT_HI_US);
    localparam logic [WIDTH_CNT_W-1:0]   ABORT_W    = WIDTH_CNT_W'(ABORT_US);
    localparam logic [WIDTH_CNT_W-1:0]   WIDTH_SAT  = {WIDTH_CNT_W{1'b1}};
    localparam logic [TIMEOUT_CNT_W-1:0] TOUT_LIMIT = TIMEOUT_CNT_W'(TIMEOUT_US);
    localparam logic [TIMEOUT_CNT_W-1:0] TOUT_SAT   = {TIMEOUT_CNT_W{1'b1}};

    logic                     sync1_r;
    logic                     sync2_r;
    logic                     level_r;
    logic                     rise_r;
    logic                     fall_r;
    ch_state_t                state_r;
    ch_state_t                state_s;
    logic [WIDTH_CNT_W-1:0]   width_r;
    logic [WIDTH_CNT_W-1:0]   width_s;
    logic [WIDTH_CNT_W-1:0]   width_inc_s;
    logic [TIMEOUT_CNT_W-1:0] tout_r;
    logic [TIMEOUT_CNT_W-1:0] tout_inc_s;
    logic                     eval_s;
    logic                     valid_s;
    logic [RADIO_VAL_W-1:0]   value_r;
    logic                     ok_r;

    // Two-flop synchroniser followed by a registered edge detector.
    // The pipeline resets to "high" so a pulse already in progress when reset
    // is released never looks like a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= sig;
            sync2_r <= sync1_r;
            level_r <= sync2_r;
            rise_r  <= sync2_r & ~level_r;
            fall_r  <= ~sync2_r & level_r;
        end
    end

    // Saturating width count including a tick that lands on this clk.
    always_comb begin
        width_inc_s = width_r;
        if (tick_1us && (width_r != WIDTH_SAT)) begin
            width_inc_s = width_r + 12'd1;
        end else begin
            width_inc_s = width_r;
        end
    end

    // Channel FSM next state; a falling edge takes priority over the abort
    // check so a pulse ending exactly at the abort width is still evaluated.
    always_comb begin
        state_s = state_r;
        width_s = width_r;
        eval_s  = 1'b0;
        case (state_r)
            CH_ARM: begin
                if (!level_r) begin
                    state_s = CH_WAIT_RISE;
                end else begin
                    state_s = CH_ARM;
                end
            end
            CH_WAIT_RISE: begin
                if (rise_r) begin
                    state_s = CH_HIGH;
                    width_s = {WIDTH_CNT_W{1'b0}};
                end else begin
                    state_s = CH_WAIT_RISE;
                end
            end
            CH_HIGH: begin
                width_s = width_inc_s;
                if (fall_r) begin
                    state_s = CH_WAIT_RISE;
                    eval_s  = 1'b1;
                end else if (width_inc_s >= ABORT_W) begin
                    state_s = CH_ARM;
                end else begin
                    state_s = CH_HIGH;
                end
            end
            default: begin
                state_s = CH_ARM;
                width_s = {WIDTH_CNT_W{1'b0}};
            end
        endcase
        valid_s = eval_s && pulse_is_valid(width_inc_s, ACC_LO_W, ACC_HI_W);
    end

    // FSM state and width counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CH_ARM;
            width_r <= {WIDTH_CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            width_r <= width_s;
        end
    end

    // Saturating time since the last valid pulse.
    always_comb begin
        tout_inc_s = tout_r;
        if (tick_1us && (tout_r != TOUT_SAT)) begin
            tout_inc_s = tout_r + 16'd1;
        end else begin
            tout_inc_s = tout_r;
        end
    end

    // Value, ok flag and timeout counter; a valid pulse wins over a timeout
    // that expires on the same clk. The value is held across a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= {RADIO_VAL_W{1'b0}};
            ok_r    <= 1'b0;
            tout_r  <= {TIMEOUT_CNT_W{1'b0}};
        end else if (valid_s) begin
            value_r <= pulse_to_value(width_inc_s, MIN_W, MAX_W);
            ok_r    <= 1'b1;
            tout_r  <= {TIMEOUT_CNT_W{1'b0}};
        end else begin
            tout_r <= tout_inc_s;
            if (tout_inc_s >= TOUT_LIMIT) begin
                ok_r <= 1'b0;
            end else begin
                ok_r <= ok_r;
            end
        end
    end

    assign value = value_r;
    assign ok    = ok_r;

endmodule

// File: rtl/radio_pulse_capture.sv
// -----------------------------------------------------------------------------
// radio_pulse_capture
// Captures NUM_CH RC receiver PWM channels as 10-bit commands with per-channel
// validity and a combined failsafe.
//   clk, rst   system clock, asynchronous active-high reset
//   tick_1us   one-clk strobe every microsecond
//   radio_sig  raw receiver pins (asynchronous)
//   radio_val  channel n value at bits [10n+9:10n], 0..1000
//   radio_ok   channel n saw a valid pulse within TIMEOUT_US
//   failsafe   any FS_MASK channel has radio_ok low (one clk behind radio_ok)
// -----------------------------------------------------------------------------
module radio_pulse_capture
    import avionics_pkg::*;
#(
    parameter int                NUM_CH       = DEF_NUM_CH,
    parameter int                MIN_US       = DEF_MIN_US,
    parameter int                MAX_US       = DEF_MAX_US,
    parameter int                ACCEPT_LO_US = DEF_ACCEPT_LO_US,
    parameter int                ACCEPT_HI_US = DEF_ACCEPT_HI_US,
    parameter int                ABORT_US     = DEF_ABORT_US,
    parameter int                TIMEOUT_US   = DEF_TIMEOUT_US,
    parameter logic [NUM_CH-1:0] FS_MASK      = NUM_CH'(8'h0F)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_1us,
    input  logic [NUM_CH-1:0]             radio_sig,
    output logic [RADIO_VAL_W*NUM_CH-1:0] radio_val,
    output logic [NUM_CH-1:0]             radio_ok,
    output logic                          failsafe
);

    logic failsafe_s;
    logic failsafe_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        radio_channel_capture #(
            .MIN_US       (MIN_US),
            .MAX_US       (MAX_US),
            .ACCEPT_LO_US (ACCEPT_LO_US),
            .ACCEPT_HI_US (ACCEPT_HI_US),
            .ABORT_US     (ABORT_US),
            .TIMEOUT_US   (TIMEOUT_US)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick_1us (tick_1us),
            .sig      (radio_sig[g]),
            .value    (radio_val[RADIO_VAL_W*g +: RADIO_VAL_W]),
            .ok       (radio_ok[g])
        );
    end

    // Any monitored channel without a recent valid pulse requests failsafe.
    always_comb begin
        failsafe_s = |(~radio_ok & FS_MASK);
    end

    // Failsafe register; asserted out of reset until the channels prove alive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            failsafe_r <= 1'b1;
        end else begin
            failsafe_r <= failsafe_s;
        end
    end

    assign failsafe = failsafe_r;

endmodule
